// File: rtl/pipe_control_unit_pkg.sv
// Shared definitions for the pipelined RV32I control unit.
// Holds the ALU op, immediate-format and result-select encodings, the opcode
// constants, the per-stage control bundles with their bubble values, and small
// helpers used by the stage registers.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU   = 2'b00,
        RES_MEM   = 2'b01,
        RES_PC4   = 2'b10,
        RES_PCIMM = 2'b11
    } result_src_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_SR   = 3'b101;

    // Full control bundle held in D/E.
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_write;
        logic        mem_access;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        alu_src;
        result_src_e result_src;
        alu_op_e     alu_ctrl;
        logic [2:0]  funct3;
    } stage_ctrl_t;

    // Only the fields still needed from M onward travel into E/M and M/W.
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_write;
        logic        mem_access;
        result_src_e result_src;
        logic [2:0]  funct3;
    } mem_ctrl_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        result_src_e result_src;
    } wb_ctrl_t;

    localparam stage_ctrl_t CTRL_BUBBLE = '{
        valid: 1'b0, reg_write: 1'b0, mem_write: 1'b0, mem_access: 1'b0,
        branch: 1'b0, jump: 1'b0, jalr: 1'b0, alu_src: 1'b0,
        result_src: RES_ALU, alu_ctrl: ALU_ADD, funct3: 3'b000
    };

    localparam mem_ctrl_t MEM_BUBBLE = '{
        valid: 1'b0, reg_write: 1'b0, mem_write: 1'b0, mem_access: 1'b0,
        result_src: RES_ALU, funct3: 3'b000
    };

    localparam wb_ctrl_t WB_BUBBLE = '{
        valid: 1'b0, reg_write: 1'b0, result_src: RES_ALU
    };

    // Reserved funct3 encodings (010/011) never take the branch.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       lt,
                                          input logic       ltu);
        logic taken;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic mem_ctrl_t to_mem(input stage_ctrl_t c);
        return '{valid: c.valid, reg_write: c.reg_write, mem_write: c.mem_write,
                 mem_access: c.mem_access, result_src: c.result_src, funct3: c.funct3};
    endfunction

    function automatic wb_ctrl_t to_wb(input mem_ctrl_t m);
        return '{valid: m.valid, reg_write: m.reg_write, result_src: m.result_src};
    endfunction

endpackage

// File: rtl/pipe_control_unit_if.sv
// Bundle of the control unit's instruction, condition, hazard and control
// output signals. clk/resetn stay as plain ports on the module.
//   master: drives the D-stage instruction fields, ALU flags and stall/flush
//           hooks; observes the decoded/pipelined control outputs.
//   slave : the control unit itself.
interface pipe_control_unit_if #(
    parameter int ALUCTRL_W = 4,
    parameter int IMMSRC_W  = 3,
    parameter int CNT_W     = 32
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 ZeroE;
    logic                 LtE;
    logic                 LtuE;
    logic                 StallE;
    logic                 FlushE;
    logic                 StallM;
    logic [IMMSRC_W-1:0]  ImmSrcD;
    logic                 IllegalD;
    logic                 PCSrcE;
    logic                 PCTargetSrcE;
    logic [ALUCTRL_W-1:0] ALUControlE;
    logic                 ALUSrcE;
    logic [1:0]           ResultSrcE;
    logic                 RegWriteM;
    logic                 MemWriteM;
    logic [2:0]           MemTypeM;
    logic                 RegWriteW;
    logic [1:0]           ResultSrcW;
    logic [CNT_W-1:0]     RetiredCount;

    modport master (
        output op, funct3, funct7b5, ZeroE, LtE, LtuE, StallE, FlushE, StallM,
        input  ImmSrcD, IllegalD, PCSrcE, PCTargetSrcE, ALUControlE, ALUSrcE,
               ResultSrcE, RegWriteM, MemWriteM, MemTypeM, RegWriteW,
               ResultSrcW, RetiredCount
    );

    modport slave (
        input  op, funct3, funct7b5, ZeroE, LtE, LtuE, StallE, FlushE, StallM,
        output ImmSrcD, IllegalD, PCSrcE, PCTargetSrcE, ALUControlE, ALUSrcE,
               ResultSrcE, RegWriteM, MemWriteM, MemTypeM, RegWriteW,
               ResultSrcW, RetiredCount
    );
endinterface

// File: rtl/pipe_control_unit_decoder.sv
// Combinational RV32I decoder for the D stage.
//   op, funct3, funct7b5 : instruction fields in D
//   ctrl                 : D-stage control bundle (bubble for unsupported opcodes)
//   imm_src              : immediate format for the extender
//   illegal              : opcode is not one of the supported classes
module rv32i_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    output stage_ctrl_t ctrl,
    output imm_src_e    imm_src,
    output logic        illegal
);

    // alt selects SUB over ADD and SRA over SRL.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e r;
        case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        imm_src = IMM_I;
        illegal = 1'b0;
        case (op)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_from_funct3(funct3, funct7b5);
            end
            OP_I: begin
                // bit 30 is an immediate bit except for SRAI
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_from_funct3(funct3, funct7b5 && (funct3 == F3_SR));
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_access = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            OP_STORE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_access = 1'b1;
                imm_src         = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                imm_src       = IMM_B;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.jalr       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_PASSB;
                imm_src        = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PCIMM;
                imm_src         = IMM_U;
            end
            default: illegal = 1'b1;
        endcase
        if (!illegal) begin
            ctrl.valid  = 1'b1;
            ctrl.funct3 = funct3;
        end
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit for the 5-stage RV32I core.
// Decodes in D, carries control through D/E, E/M and M/W, evaluates the branch
// condition in E and counts retired instructions.
//   clk    : core clock
//   resetn : asynchronous active-low reset
//   bus    : instruction fields, ALU flags, stall/flush hooks and all control
//            outputs (see pipe_control_unit_if)
module pipe_control_unit
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int IMMSRC_W  = 3,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    pipe_control_unit_if.slave   bus
);

    stage_ctrl_t      dec_ctrl;
    imm_src_e         dec_imm;
    logic             dec_illegal;

    stage_ctrl_t      de_q;
    mem_ctrl_t        em_q;
    wb_ctrl_t         mw_q;
    logic [CNT_W-1:0] count;

    rv32i_decoder u_decoder (
        .op       (bus.op),
        .funct3   (bus.funct3),
        .funct7b5 (bus.funct7b5),
        .ctrl     (dec_ctrl),
        .imm_src  (dec_imm),
        .illegal  (dec_illegal)
    );

    // StallM outranks FlushE, so a flush arriving during a memory wait is lost
    // and must be re-issued by the hazard unit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            de_q  <= CTRL_BUBBLE;
            em_q  <= MEM_BUBBLE;
            mw_q  <= WB_BUBBLE;
            count <= '0;
        end else begin
            if (!bus.StallM) begin
                if (bus.FlushE) begin
                    de_q <= CTRL_BUBBLE;
                end else if (!bus.StallE) begin
                    de_q <= dec_ctrl;
                end
                em_q <= to_mem(de_q);
            end
            // the held M instruction must not also appear in W
            mw_q <= bus.StallM ? WB_BUBBLE : to_wb(em_q);
            if (mw_q.valid) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign bus.ImmSrcD      = IMMSRC_W'(dec_imm);
    assign bus.IllegalD     = dec_illegal;

    assign bus.PCSrcE       = ((de_q.branch & branch_taken(de_q.funct3, bus.ZeroE, bus.LtE, bus.LtuE))
                               | de_q.jump) & ~bus.StallM;
    assign bus.PCTargetSrcE = de_q.jalr;
    assign bus.ALUControlE  = ALUCTRL_W'(de_q.alu_ctrl);
    assign bus.ALUSrcE      = de_q.alu_src;
    assign bus.ResultSrcE   = de_q.result_src;

    assign bus.RegWriteM    = em_q.reg_write;
    assign bus.MemWriteM    = em_q.mem_write;
    assign bus.MemTypeM     = em_q.mem_access ? em_q.funct3 : 3'b000;

    assign bus.RegWriteW    = mw_q.reg_write;
    assign bus.ResultSrcW   = mw_q.result_src;
    assign bus.RetiredCount = count;

endmodule
